mbinit_param_tx: RTL and testbench
==================================

Name: mbinit_param_tx

Overview:
- Initiator side of the MBINIT.PARAM exchange.
- Latches the local PHY capability fields and sends them to the link partner as a PARAM configuration request over the sideband TX handshake.
- Waits for the partner's PARAM response, then validates it and reports the negotiated max data rate.
- Sits in the MBINIT sequencer alongside the partner-request checker; its outputs gate progression to the next MBINIT substate.

Parameters:
TIMEOUT_CYCLES, 8000, cycles from SEND entry until timeout (covers SEND and WAIT_RESP together)
CNT_W, 14, timeout counter width; must hold TIMEOUT_CYCLES-1
REQ_CODE, 4'h1, sideband message code for PARAM configuration request
RESP_CODE, 4'h2, sideband message code for PARAM configuration response
MAX_RETRY, 2, extra request attempts; used only when PARAM_RETRY_EN is defined

Ports:
CLK  in  1  clock
rst_n  in  1  async active-low reset
i_Enable_Param  in  1  level; high runs the exchange, low aborts or clears
i_Local_VoltageSwing  in  5  local TX voltage swing
i_Local_MaxDataRate  in  3  local max data rate code
i_Local_ClockMode  in  1  local clock mode
i_Local_PhaseClock  in  1  local clock phase
o_TX_Valid  out  1  request message valid
i_TX_Ready  in  1  sideband TX accepts message
o_TX_MsgCode  out  4  message code (REQ_CODE while valid, else 0)
o_TX_Data  out  10  {VoltageSwing[9:5], MaxDataRate[4:2], ClockMode[1], PhaseClock[0]}
i_RX_Valid  in  1  received sideband message strobe (1 cycle)
i_RX_MsgCode  in  4  received message code
i_RX_Data  in  10  received payload, same packing as o_TX_Data
o_Finish_Param  out  1  exchange complete (held in DONE)
o_Successful_Param  out  1  response accepted
o_Final_MaxDataRate  out  3  negotiated rate; 0 unless successful
o_Timeout  out  1  exchange ended by timeout

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0, latched fields 0.
- States: IDLE, SEND, WAIT_RESP, DONE.
- IDLE:
  - Enable=1 → SEND next cycle.
  - Local fields are latched on this transition and are not resampled afterwards.
  - Counter cleared.
- SEND:
  - o_TX_Valid=1, o_TX_MsgCode=REQ_CODE, o_TX_Data = latched fields, held stable until accepted.
  - TX_Valid & TX_Ready in the same cycle → WAIT_RESP next cycle; o_TX_Valid falls.
- WAIT_RESP:
  - Accept only when i_RX_Valid=1 and i_RX_MsgCode==RESP_CODE; all other messages are ignored.
  - Success requires all of: resp ClockMode == latched ClockMode, resp PhaseClock == latched PhaseClock, resp MaxDataRate != 0, resp MaxDataRate <= latched MaxDataRate.
  - On success: Successful=1, Final_MaxDataRate = resp rate.
  - On failure: both 0.
  - Either outcome → DONE next cycle.
- Timeout:
  - Counter increments every cycle in SEND and WAIT_RESP.
  - Reaching TIMEOUT_CYCLES-1 → DONE with o_Timeout=1, Successful=0, Final=0.
  - A valid response in the same cycle as the timeout wins; o_Timeout stays 0.
- DONE:
  - o_Finish_Param=1; result outputs are held.
  - Enable low → IDLE next cycle, all outputs cleared.
  - No restart while enable stays high.
- Abort: enable low in SEND or WAIT_RESP → IDLE next cycle.
  - o_TX_Valid drops even if not yet accepted.
  - Outputs are cleared and Finish is not asserted.
- Outputs are registered; result is visible 1 cycle after the accepting response strobe.

Optional Feature:
PARAM_RETRY_EN
- Defined:
  - A failed compare or a timeout returns to SEND (counter cleared, same latched fields) if retries used < MAX_RETRY.
  - After the last attempt, go to DONE with the final result.
  - Retry count clears in IDLE.
- Undefined: single attempt only; MAX_RETRY is unused.

Test Plan:
1. Local {VS=5'h0C, rate=3'd4, CM=1, PC=0}; enable; ready on 3rd SEND cycle; response RESP_CODE {rate=3'd3, CM=1, PC=0} → o_TX_Data=10'h192 held over 3 cycles; Finish=1, Successful=1, Final=3, Timeout=0.
2. Same setup with response CM=0 → Finish=1, Successful=0, Final=0; with PARAM_RETRY_EN, 3 requests total before DONE.
3. Response rate=3'd5 with local rate 3'd4 → Successful=0; response rate=0 → Successful=0.
4. TIMEOUT_CYCLES=16, no response → Finish and Timeout at cycle 16 after SEND entry; response arriving in the timeout cycle → Successful=1, Timeout=0.
5. Enable dropped while in SEND with ready low → o_TX_Valid=0 next cycle, state IDLE, Finish=0; re-enable starts a fresh request.
6. In WAIT_RESP, inject message code 4'h3 then RESP_CODE → first is ignored, second is accepted; reset asserted in DONE → all outputs 0 immediately.

Source files
------------

// File: rtl/mbinit_param_tx.sv
// mbinit_param_tx: initiator side of MBINIT.PARAM. Sends the latched local PHY capabilities and validates the partner's response.
// Build option PARAM_RETRY_EN re-sends the request after a failed compare or a timeout, up to MAX_RETRY extra times.
module mbinit_param_tx #(
  parameter int         TIMEOUT_CYCLES = 8000,
  parameter int         CNT_W          = 14,
  parameter logic [3:0] REQ_CODE       = 4'h1,
  parameter logic [3:0] RESP_CODE      = 4'h2,
  parameter int         MAX_RETRY      = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_Enable_Param,
  input  logic [4:0] i_Local_VoltageSwing,
  input  logic [2:0] i_Local_MaxDataRate,
  input  logic       i_Local_ClockMode,
  input  logic       i_Local_PhaseClock,
  output logic       o_TX_Valid,
  input  logic       i_TX_Ready,
  output logic [3:0] o_TX_MsgCode,
  output logic [9:0] o_TX_Data,
  input  logic       i_RX_Valid,
  input  logic [3:0] i_RX_MsgCode,
  input  logic [9:0] i_RX_Data,
  output logic       o_Finish_Param,
  output logic       o_Successful_Param,
  output logic [2:0] o_Final_MaxDataRate,
  output logic       o_Timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_RESP, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PARAM_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0 * MAX_RETRY;
`endif
  localparam int RW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       fields_q;
  logic [RW-1:0]    retry_q;
  logic             tx_valid_q;
  logic             finish_q;
  logic             success_q;
  logic             timeout_q;
  logic [2:0]       final_q;

  logic       cnt_expired;
  logic       resp_hit;
  logic       resp_ok;
  logic [2:0] resp_rate;
  logic       can_retry;
  logic       attempt_end;
  logic       attempt_ok;
  logic       attempt_to;
  logic       unused_rx_swing;

  // The partner's swing field plays no part in acceptance.
  assign unused_rx_swing = ^i_RX_Data[9:5];

  assign resp_rate   = i_RX_Data[4:2];
  assign resp_hit    = i_RX_Valid && (i_RX_MsgCode == RESP_CODE);
  assign resp_ok     = (i_RX_Data[1] == fields_q[1]) && (i_RX_Data[0] == fields_q[0]) &&
                       (resp_rate != 3'd0) && (resp_rate <= fields_q[4:2]);
  assign cnt_expired = (cnt_q == CNT_LAST);
  assign can_retry   = (int'(retry_q) < RETRY_LIMIT);

  // A response seen in the expiry cycle takes precedence over the timeout.
  always_comb begin
    attempt_end = 1'b0;
    attempt_ok  = 1'b0;
    attempt_to  = 1'b0;
    case (state_q)
      ST_SEND: begin
        if (cnt_expired) begin
          attempt_end = 1'b1;
          attempt_to  = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_hit) begin
          attempt_end = 1'b1;
          attempt_ok  = resp_ok;
        end else if (cnt_expired) begin
          attempt_end = 1'b1;
          attempt_to  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fields_q   <= '0;
      retry_q    <= '0;
      tx_valid_q <= 1'b0;
      finish_q   <= 1'b0;
      success_q  <= 1'b0;
      timeout_q  <= 1'b0;
      final_q    <= '0;
    end else if (!i_Enable_Param) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      tx_valid_q <= 1'b0;
      finish_q   <= 1'b0;
      success_q  <= 1'b0;
      timeout_q  <= 1'b0;
      final_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fields_q   <= {i_Local_VoltageSwing, i_Local_MaxDataRate, i_Local_ClockMode, i_Local_PhaseClock};
          cnt_q      <= '0;
          retry_q    <= '0;
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND, ST_WAIT_RESP: begin
          cnt_q <= cnt_q + 1'b1;
          if (attempt_end) begin
            if (!attempt_ok && can_retry) begin
              state_q    <= ST_SEND;
              cnt_q      <= '0;
              tx_valid_q <= 1'b1;
              retry_q    <= retry_q + 1'b1;
            end else begin
              state_q    <= ST_DONE;
              tx_valid_q <= 1'b0;
              finish_q   <= 1'b1;
              success_q  <= attempt_ok;
              final_q    <= attempt_ok ? resp_rate : 3'd0;
              timeout_q  <= attempt_to;
            end
          end else if ((state_q == ST_SEND) && i_TX_Ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_WAIT_RESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_TX_Valid          = tx_valid_q;
  assign o_TX_MsgCode        = tx_valid_q ? REQ_CODE : 4'h0;
  assign o_TX_Data           = tx_valid_q ? fields_q : 10'h000;
  assign o_Finish_Param      = finish_q;
  assign o_Successful_Param  = success_q;
  assign o_Final_MaxDataRate = final_q;
  assign o_Timeout           = timeout_q;

endmodule

// File: tb/tb_mbinit_param_tx.sv
// Scoreboard bench for mbinit_param_tx: stimulus queues expected requests/results, a negedge monitor pops and compares.
module tb_mbinit_param_tx;

  localparam int         T         = 16;
  localparam logic [3:0] REQ_CODE  = 4'h1;
  localparam logic [3:0] RESP_CODE = 4'h2;
`ifdef PARAM_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [4:0] vs = '0;
  logic [2:0] rate = '0;
  logic       cm = 1'b0;
  logic       pc = 1'b0;
  logic       rdy = 1'b0;
  logic       rxv = 1'b0;
  logic [3:0] rxc = '0;
  logic [9:0] rxd = '0;
  logic       o_TX_Valid;
  logic [3:0] o_TX_MsgCode;
  logic [9:0] o_TX_Data;
  logic       o_Finish_Param;
  logic       o_Successful_Param;
  logic [2:0] o_Final_MaxDataRate;
  logic       o_Timeout;

  mbinit_param_tx #(
    .TIMEOUT_CYCLES(T), .CNT_W(14), .REQ_CODE(REQ_CODE), .RESP_CODE(RESP_CODE), .MAX_RETRY(2)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .i_Enable_Param(en),
    .i_Local_VoltageSwing(vs), .i_Local_MaxDataRate(rate),
    .i_Local_ClockMode(cm), .i_Local_PhaseClock(pc),
    .o_TX_Valid(o_TX_Valid), .i_TX_Ready(rdy), .o_TX_MsgCode(o_TX_MsgCode), .o_TX_Data(o_TX_Data),
    .i_RX_Valid(rxv), .i_RX_MsgCode(rxc), .i_RX_Data(rxd),
    .o_Finish_Param(o_Finish_Param), .o_Successful_Param(o_Successful_Param),
    .o_Final_MaxDataRate(o_Final_MaxDataRate), .o_Timeout(o_Timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       succ;
    logic [2:0] rate;
    logic       to;
    int         fcyc;
  } res_t;

  res_t       exp_res[$];
  logic [9:0] exp_req[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push_res(input logic s, input logic [2:0] r, input logic t, input int fc);
    res_t e;
    e.succ = s; e.rate = r; e.to = t; e.fcyc = fc;
    exp_res.push_back(e);
  endtask

  // Acceptance rule: clock mode and phase must match, rate nonzero and not above ours.
  function automatic bit resp_good(input logic [9:0] r, input logic [9:0] l);
    int rr;
    int lr;
    rr = int'(r[4:2]);
    lr = int'(l[4:2]);
    return (r[1] == l[1]) && (r[0] == l[0]) && (rr != 0) && (rr <= lr);
  endfunction

  // Monitor: one expected request per rising TX_Valid, one expected result per rising Finish.
  logic       prev_fin = 1'b0;
  logic       prev_val = 1'b0;
  logic [9:0] cur_req = '0;
  always @(negedge CLK) begin
    if (rst_n) begin
      if (o_TX_Valid && !prev_val) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_request", 32'(o_TX_Data), 32'hFFFF_FFFF);
        end else begin
          cur_req = exp_req.pop_front();
          chk("req_data", 32'(o_TX_Data), 32'(cur_req));
          chk("req_code", 32'(o_TX_MsgCode), 32'(REQ_CODE));
        end
      end else if (o_TX_Valid) begin
        chk("req_data_stable", 32'(o_TX_Data), 32'(cur_req));
      end else begin
        chk("idle_code", 32'(o_TX_MsgCode), 32'd0);
      end
      if (o_Finish_Param && !prev_fin) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_finish", 32'(o_Finish_Param), 32'd0);
        end else begin
          res_t e;
          e = exp_res.pop_front();
          chk("finish_cycle", 32'(cyc), 32'(e.fcyc));
          chk("successful", 32'(o_Successful_Param), 32'(e.succ));
          chk("final_rate", 32'(o_Final_MaxDataRate), 32'(e.rate));
          chk("timeout", 32'(o_Timeout), 32'(e.to));
        end
      end
    end
    prev_fin = o_Finish_Param;
    prev_val = o_TX_Valid;
  end

  task automatic wait_valid(output bit got, output int s);
    got = 1'b0;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_TX_Valid) begin
        got = 1'b1;
        s = cyc;
        return;
      end
      @(negedge CLK);
    end
    checks++;
    errors++;
    $display("FAIL tx_valid_wait: got 0 expected 1 within 8 cycles (cycle %0d)", cyc);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_valid"}, 32'(o_TX_Valid), 32'd0);
    chk({nm, "_finish"}, 32'(o_Finish_Param), 32'd0);
    chk({nm, "_success"}, 32'(o_Successful_Param), 32'd0);
    chk({nm, "_rate"}, 32'(o_Final_MaxDataRate), 32'd0);
    chk({nm, "_timeout"}, 32'(o_Timeout), 32'd0);
  endtask

  // kind: 0 respond, 1 no response (timeout), 2 respond in the expiry cycle, 3 foreign code then respond.
  task automatic exchange(input logic [9:0] f, input int rdly, input int kind, input logic [9:0] rd,
                          input int rsdly, input bit rst_done);
    int s, e, att;
    bit got, ok, last;
    exp_req.push_back(f);
    {vs, rate, cm, pc} = f;
    en = 1'b1;
    e = cyc;
    att = 0;
    @(negedge CLK);
    forever begin
      wait_valid(got, s);
      if (!got) begin
        en = 1'b0;
        @(negedge CLK);
        return;
      end
      if (att == 0) chk("send_entry", 32'(s), 32'(e + 1));
      {vs, rate, cm, pc} = 10'($urandom);
      repeat (rdly) @(negedge CLK);
      rdy = 1'b1;
      @(negedge CLK);
      rdy = 1'b0;
      chk("tx_valid_drop", 32'(o_TX_Valid), 32'd0);
      ok = (kind != 1) && resp_good(rd, f);
      last = ok || (att >= RETRIES);
      if (kind == 1) begin
        if (last) push_res(1'b0, 3'd0, 1'b1, s + T);
        else exp_req.push_back(f);
        while (cyc < s + T) @(negedge CLK);
      end else begin
        if (kind == 3) begin
          rxv = 1'b1; rxc = 4'($urandom_range(3, 15)); rxd = rd;
          @(negedge CLK);
          rxv = 1'b0; rxc = '0; rxd = '0;
        end
        if (kind == 2) while (cyc < s + T - 1) @(negedge CLK);
        else repeat (rsdly) @(negedge CLK);
        if (last) push_res(ok, ok ? rd[4:2] : 3'd0, 1'b0, cyc + 1);
        else exp_req.push_back(f);
        rxv = 1'b1; rxc = RESP_CODE; rxd = rd;
        @(negedge CLK);
        rxv = 1'b0; rxc = '0; rxd = '0;
      end
      att++;
      if (last) break;
    end
    chk("finish_seen", 32'(o_Finish_Param), 32'd1);
    repeat (2) begin
      @(negedge CLK);
      chk("done_hold_finish", 32'(o_Finish_Param), 32'd1);
      chk("done_no_restart", 32'(o_TX_Valid), 32'd0);
    end
    if (rst_done) begin
      rst_n = 1'b0;
      #1;
      chk_cleared("reset_in_done");
      en = 1'b0;
      @(negedge CLK);
      rst_n = 1'b1;
    end else begin
      en = 1'b0;
      @(negedge CLK);
      chk_cleared("disable_clear");
    end
    $display("exchange fields=%h kind=%0d resp=%h attempts=%0d ok=%0d", f, kind, rd, att, ok);
    @(negedge CLK);
  endtask

  task automatic abort_test(input logic [9:0] f, input bit in_wait);
    int s;
    bit got;
    exp_req.push_back(f);
    {vs, rate, cm, pc} = f;
    en = 1'b1;
    @(negedge CLK);
    wait_valid(got, s);
    if (in_wait) begin
      rdy = 1'b1;
      @(negedge CLK);
      rdy = 1'b0;
    end else begin
      @(negedge CLK);
    end
    en = 1'b0;
    @(negedge CLK);
    chk_cleared("abort");
    @(negedge CLK);
    chk("abort_stays_idle", 32'(o_TX_Valid), 32'd0);
    $display("abort fields=%h in_wait=%0d", f, in_wait);
  endtask

  initial begin
    logic [9:0] f, rd;
    int kind;
    repeat (2) @(negedge CLK);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge CLK);
    chk_cleared("post_reset");

    exchange(10'h192, 2, 0, {5'h00, 3'd3, 1'b1, 1'b0}, 1, 1'b0);
    exchange(10'h192, 0, 0, {5'h00, 3'd3, 1'b0, 1'b0}, 2, 1'b0);
    exchange(10'h192, 1, 0, {5'h00, 3'd5, 1'b1, 1'b0}, 0, 1'b0);
    exchange(10'h192, 1, 0, {5'h00, 3'd0, 1'b1, 1'b0}, 3, 1'b0);
    exchange(10'h192, 3, 0, {5'h1F, 3'd4, 1'b1, 1'b0}, 0, 1'b0);
    exchange(10'h192, 0, 1, 10'h000, 0, 1'b0);
    exchange(10'h192, 1, 2, {5'h00, 3'd2, 1'b1, 1'b0}, 0, 1'b0);
    abort_test(10'h192, 1'b0);
    exchange(10'h2A5, 0, 0, 10'h005, 1, 1'b0);
    abort_test(10'h3FF, 1'b1);
    exchange(10'h192, 1, 3, {5'h00, 3'd1, 1'b1, 1'b0}, 2, 1'b1);

    for (int n = 0; n < 40; n++) begin
      f = 10'($urandom);
      rd = {5'($urandom), 3'($urandom), f[1] ^ ($urandom_range(0, 3) == 0), f[0] ^ ($urandom_range(0, 3) == 0)};
      kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      exchange(f, int'($urandom_range(0, 3)), kind, rd, int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
    end

    chk("pending_results", 32'(exp_res.size()), 32'd0);
    chk("pending_requests", 32'(exp_req.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
